// File: rtl/ccff_pkg.sv
// Shared types and geometry helpers for the configuration-chain loader.
package ccff_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } ccff_state_e;

    // Number of bitstream / readback words needed to cover the chain (N).
    function automatic int ccff_num_words(input int chain_len, input int data_w);
        return (chain_len + data_w - 1) / data_w;
    endfunction

    // Bits actually used from the final word (R); the rest are discarded.
    function automatic int ccff_last_bits(input int chain_len, input int data_w);
        return chain_len - (ccff_num_words(chain_len, data_w) - 1) * data_w;
    endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Bitstream-in and readback-out word streams of the chain loader.
// Handshake: a word moves on a prog_clk edge where valid && ready are both 1;
// the producer keeps data stable while valid && !ready, and ready never
// depends on valid.
interface ccff_chain_loader_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] rb_data;
    logic              rb_valid;
    logic              rb_ready;

    // Bitstream source / readback consumer side.
    modport master (
        output wr_data, wr_valid, rb_ready,
        input  wr_ready, rb_data, rb_valid
    );

    // Loader side.
    modport slave (
        input  wr_data, wr_valid, rb_ready,
        output wr_ready, rb_data, rb_valid
    );
endinterface

// File: rtl/ccff_rb_packer.sv
// Serial-to-parallel packer for chain readback bits, MSB first. A completed
// word is held on rb_data until accepted. One extra bit (already in flight
// when the consumer stops) is absorbed in the collect register; a completed
// word that cannot be handed over waits there as "pending". Assumes DATA_W >= 2.
module ccff_rb_packer #(
    parameter int DATA_W = 32
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              bit_valid,
    input  logic              bit_in,
    input  logic              bit_last,
    output logic [DATA_W-1:0] rb_data,
    output logic              rb_valid,
    input  logic              rb_ready,
    output logic              stall,
    output logic              pending
);
    localparam int K_W   = $clog2(DATA_W + 1);
    localparam int IDX_W = $clog2(DATA_W);

    logic [DATA_W-1:0] col_q, col_d;
    logic [K_W-1:0]    k_q, k_d;
    logic              pend_q, pend_d;
    logic [DATA_W-1:0] rb_data_q, rb_data_d;
    logic              rb_valid_q, rb_valid_d;
    logic              out_free;
    logic              complete;
    logic [IDX_W-1:0]  idx;

    // Collect bits, hand finished words to the output register, raise stall.
    always_comb begin
        col_d      = col_q;
        k_d        = k_q;
        pend_d     = pend_q;
        rb_data_d  = rb_data_q;
        rb_valid_d = rb_valid_q && !rb_ready;
        out_free   = !rb_valid_q || rb_ready;
        complete   = bit_valid && ((k_q == K_W'(DATA_W - 1)) || bit_last);
        idx        = IDX_W'(DATA_W - 1 - int'(k_q));
        if (bit_valid) begin
            col_d[idx] = bit_in;
            k_d        = k_q + K_W'(1);
        end
        if (complete || pend_q) begin
            if (out_free) begin
                rb_data_d  = col_d;
                rb_valid_d = 1'b1;
                col_d      = '0;
                k_d        = '0;
                pend_d     = 1'b0;
            end else begin
                pend_d = 1'b1;
            end
        end
        // Block the next shift if a full word is (or is about to be) stuck.
        stall = (rb_valid_q && !rb_ready) || pend_q || (complete && !rb_ready);
    end

    // Packer state registers.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            col_q      <= '0;
            k_q        <= '0;
            pend_q     <= 1'b0;
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            col_q      <= col_d;
            k_q        <= k_d;
            pend_q     <= pend_d;
            rb_data_q  <= rb_data_d;
            rb_valid_q <= rb_valid_d;
        end
    end

    assign rb_data  = rb_data_q;
    assign rb_valid = rb_valid_q;
    assign pending  = pend_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration-chain master: shifts bitstream words into ccff_head MSB first
// and packs ccff_tail readback into words. Head and enable are registered, so
// a bit is chosen one cycle before the chain actually shifts it.
module ccff_chain_loader
    import ccff_pkg::*;
#(
    parameter int CHAIN_LEN = 1024,
    parameter int DATA_W    = 32
) (
    input  logic                 prog_clk,
    input  logic                 pReset,
    input  logic                 start,
    ccff_chain_loader_if.slave   bus,
    output logic                 ccff_head,
    input  logic                 ccff_tail,
    output logic                 prog_clk_en,
    output logic                 busy,
    output logic                 done,
    output ccff_state_e          dbg_state
);
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
    localparam int CW1       = CNT_W + 1;
    localparam int BN_W      = $clog2(DATA_W + 1);
    localparam int N_WORDS   = ccff_num_words(CHAIN_LEN, DATA_W);
    localparam int LAST_BITS = ccff_last_bits(CHAIN_LEN, DATA_W);
    localparam int WD_W      = $clog2(N_WORDS + 1);

    ccff_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic [BN_W-1:0]   bufn_q, bufn_d;
    logic [WD_W-1:0]   words_q, words_d;
    logic              head_q, head_d;
    logic              en_q, en_d;
    logic              done_q, done_d;
    logic              issue;
    logic              wr_ready_c;
    logic              last_bit;
    logic              pk_stall;
    logic              pk_pend;

    // Next state, input buffer, shift issue and bit counter.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        bufn_d     = bufn_q;
        words_d    = words_q;
        head_d     = head_q;
        en_d       = 1'b0;
        done_d     = 1'b0;
        issue      = 1'b0;
        wr_ready_c = 1'b0;
        last_bit   = en_q && (cnt_q == CNT_W'(CHAIN_LEN - 1));
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    buf_d   = '0;
                    bufn_d  = '0;
                    words_d = '0;
                end
            end
            LOAD: begin
                issue = (bufn_q != '0) && !pk_stall &&
                        (({1'b0, cnt_q} + CW1'(en_q)) < CW1'(CHAIN_LEN));
                // Refill when empty or emptying now, so words stream gap-free.
                wr_ready_c = ((bufn_q == '0) || ((bufn_q == BN_W'(1)) && issue)) &&
                             (words_q < WD_W'(N_WORDS));
                if (issue) begin
                    en_d   = 1'b1;
                    head_d = buf_q[DATA_W-1];
                    buf_d  = buf_q << 1;
                    bufn_d = bufn_q - BN_W'(1);
                end
                if (bus.wr_valid && wr_ready_c) begin
                    buf_d   = bus.wr_data;
                    bufn_d  = (words_q == WD_W'(N_WORDS - 1)) ? BN_W'(LAST_BITS) : BN_W'(DATA_W);
                    words_d = words_q + WD_W'(1);
                end
                if (en_q) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (bus.rb_valid && bus.rb_ready && !pk_pend) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
            bufn_q  <= '0;
            words_q <= '0;
            head_q  <= 1'b0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            bufn_q  <= bufn_d;
            words_q <= words_d;
            head_q  <= head_d;
            en_q    <= en_d;
            done_q  <= done_d;
        end
    end

    ccff_rb_packer #(.DATA_W(DATA_W)) u_packer (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .bit_valid(en_q),
        .bit_in   (ccff_tail),
        .bit_last (last_bit),
        .rb_data  (bus.rb_data),
        .rb_valid (bus.rb_valid),
        .rb_ready (bus.rb_ready),
        .stall    (pk_stall),
        .pending  (pk_pend)
    );

    assign bus.wr_ready = wr_ready_c;
    assign ccff_head    = head_q;
    assign prog_clk_en  = en_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: two instances (64-bit and 40-bit chains), each
// attached to a behavioural chain model; expected readback and final chain
// contents are derived from the preload and the written words.
module tb_ccff_chain_loader;
    import ccff_pkg::*;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        p_reset;
    logic        start_a, start_b;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        rb_ready;
    logic        sel;
    logic        pre_a, pre_b;
    logic [63:0] pre_val;

    ccff_chain_loader_if #(.DATA_W(W)) bus_a ();
    ccff_chain_loader_if #(.DATA_W(W)) bus_b ();

    assign bus_a.wr_data  = wr_data;
    assign bus_a.wr_valid = wr_valid;
    assign bus_a.rb_ready = rb_ready;
    assign bus_b.wr_data  = wr_data;
    assign bus_b.wr_valid = wr_valid;
    assign bus_b.rb_ready = rb_ready;

    logic        head_a, tail_a, en_a, busy_a, done_a;
    logic        head_b, tail_b, en_b, busy_b, done_b;
    ccff_state_e st_a, st_b;
    logic [63:0] chain_a;
    logic [39:0] chain_b;

    ccff_chain_loader #(.CHAIN_LEN(64), .DATA_W(W)) dut_a (
        .prog_clk(clk), .pReset(p_reset), .start(start_a), .bus(bus_a),
        .ccff_head(head_a), .ccff_tail(tail_a), .prog_clk_en(en_a),
        .busy(busy_a), .done(done_a), .dbg_state(st_a)
    );

    ccff_chain_loader #(.CHAIN_LEN(40), .DATA_W(W)) dut_b (
        .prog_clk(clk), .pReset(p_reset), .start(start_b), .bus(bus_b),
        .ccff_head(head_b), .ccff_tail(tail_b), .prog_clk_en(en_b),
        .busy(busy_b), .done(done_b), .dbg_state(st_b)
    );

    // Behavioural configuration chains: shift toward the tail on enabled edges.
    assign tail_a = chain_a[63];
    assign tail_b = chain_b[39];
    always @(posedge clk) begin
        if (pre_a) chain_a <= pre_val;
        else if (en_a) chain_a <= {chain_a[62:0], head_a};
        if (pre_b) chain_b <= pre_val[39:0];
        else if (en_b) chain_b <= {chain_b[38:0], head_b};
    end

    // Selected-instance view.
    logic        cur_wr_ready, cur_rb_valid, cur_head, cur_en, cur_busy, cur_done;
    logic [31:0] cur_rb_data;
    logic [63:0] cur_chain;
    ccff_state_e cur_state;
    assign cur_wr_ready = sel ? bus_b.wr_ready : bus_a.wr_ready;
    assign cur_rb_valid = sel ? bus_b.rb_valid : bus_a.rb_valid;
    assign cur_rb_data  = sel ? bus_b.rb_data  : bus_a.rb_data;
    assign cur_head     = sel ? head_b : head_a;
    assign cur_en       = sel ? en_b   : en_a;
    assign cur_busy     = sel ? busy_b : busy_a;
    assign cur_done     = sel ? done_b : done_a;
    assign cur_state    = sel ? st_b   : st_a;
    assign cur_chain    = sel ? {24'h0, chain_b} : chain_a;

    // ---------------- scoreboard ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] wq[$];
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_start(input logic s, input logic v);
        if (s) start_b = v;
        else start_a = v;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_wr_ready"}, cur_wr_ready, 0);
        check_eq({tag, "_rb_valid"}, cur_rb_valid, 0);
        check_eq({tag, "_rb_data"},  cur_rb_data,  0);
        check_eq({tag, "_head"},     cur_head,     0);
        check_eq({tag, "_en"},       cur_en,       0);
        check_eq({tag, "_busy"},     cur_busy,     0);
        check_eq({tag, "_done"},     cur_done,     0);
        check_eq({tag, "_state"},    cur_state,    IDLE);
    endtask

    // One full load on instance s. wmode: 0 always valid, 1 toggle 3/3,
    // 2 random. rmode: 0 always ready, 1 low until 20 cycles after the first
    // rb_valid, 2 random. abort_at>0 resets after that many shifts.
    task automatic run_load(input logic s, input logic [63:0] preload, input int wmode,
                            input int rmode, input int abort_at, input bit poke_start);
        int          len = s ? 40 : 64;
        int          nw  = (len + W - 1) / W;
        int          widx = 0, cyc = 0, n_shift = 0, first_en = -1, last_en = -1;
        int          first_hs = -1, first_rbv = -1, done_cnt = 0, tail_cyc = 0;
        int          stall_viol = 0, hold_viol = 0;
        logic [31:0] ew[2];
        logic [63:0] exp_chain;
        logic        hold_prev = 1'b0;
        logic [31:0] hold_data = '0;
        bit          aborted = 1'b0;

        // Reference model: readback is the preload read MSB first, packed into
        // left-aligned words; the chain ends up holding the first len written bits.
        ew[0] = '0;
        ew[1] = '0;
        exp_chain = '0;
        for (int k = 0; k < len; k++) begin
            ew[k / W][W - 1 - (k % W)] = preload[len - 1 - k];
            exp_chain[len - 1 - k]     = wq[k / W][W - 1 - (k % W)];
        end
        exp_q.delete();
        for (int i = 0; i < nw; i++) exp_q.push_back(ew[i]);
        obs_q.delete();

        sel = s;
        @(posedge clk); #1;
        pre_val = preload;
        if (s) pre_b = 1'b1;
        else pre_a = 1'b1;
        @(posedge clk); #1;
        pre_a = 1'b0;
        pre_b = 1'b0;
        set_start(s, 1'b1);
        @(posedge clk); #1;
        set_start(s, 1'b0);

        while (cyc < 3000) begin
            case (wmode)
                0:       wr_valid = (widx < nw);
                1:       wr_valid = (widx < nw) && ((cyc % 6) < 3);
                default: wr_valid = (widx < nw) && ($urandom_range(0, 1) == 1);
            endcase
            wr_data = wr_valid ? wq[widx] : $urandom;
            case (rmode)
                0:       rb_ready = 1'b1;
                1:       rb_ready = (first_rbv >= 0) && (cyc >= first_rbv + 20);
                default: rb_ready = ($urandom_range(0, 1) == 1);
            endcase
            set_start(s, poke_start && (cyc == 10));

            @(negedge clk);
            if (poke_start && cyc == 10) check_eq("start_in_load_state", cur_state, LOAD);
            if (cur_en) begin
                n_shift++;
                if (first_en < 0) first_en = cyc;
                last_en = cyc;
            end
            if (wr_valid && cur_wr_ready) begin
                if (first_hs < 0) first_hs = cyc;
                widx++;
            end
            if (cur_rb_valid && first_rbv < 0) first_rbv = cyc;
            if (hold_prev && (!cur_rb_valid || cur_rb_data !== hold_data)) hold_viol++;
            if (rmode == 1 && cur_rb_valid && !rb_ready && cur_en) stall_viol++;
            if (cur_rb_valid && rb_ready) obs_q.push_back(cur_rb_data);
            hold_prev = cur_rb_valid && !rb_ready;
            hold_data = cur_rb_data;
            if (cur_done) done_cnt++;

            if (abort_at > 0 && n_shift == abort_at) begin
                p_reset  = 1'b1;
                wr_valid = 1'b0;
                @(posedge clk); #1;
                p_reset = 1'b0;
                @(negedge clk);
                check_reset_outputs("abort");
                check_eq("abort_no_done", done_cnt, 0);
                aborted = 1'b1;
                break;
            end
            if (done_cnt > 0) tail_cyc++;
            if (tail_cyc > 3) break;
            @(posedge clk); #1;
            cyc++;
        end
        wr_valid = 1'b0;
        rb_ready = 1'b0;
        set_start(s, 1'b0);

        if (!aborted) begin
            check_eq("shift_count", n_shift, len);
            check_eq("words_taken", widx, nw);
            check_eq("rb_word_count", obs_q.size(), exp_q.size());
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
                check_eq($sformatf("rb_word%0d", i), obs_q[i], exp_q[i]);
            check_eq("chain_contents", cur_chain, exp_chain);
            check_eq("done_pulses", done_cnt, 1);
            check_eq("rb_hold_stable", hold_viol, 0);
            check_eq("idle_after_done", cur_busy, 0);
            if (wmode == 0 && rmode == 0) begin
                check_eq("no_gaps", last_en - first_en + 1, len);
                check_eq("first_en_latency", first_en - first_hs, 2);
            end
            if (rmode == 1) check_eq("en_low_while_rb_stalled", stall_viol, 0);
        end
    endtask

    task automatic fill_random_words(input int n);
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back($urandom);
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] w1;

    initial begin
        p_reset  = 1'b1;
        start_a  = 1'b0;
        start_b  = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        rb_ready = 1'b0;
        sel      = 1'b0;
        pre_a    = 1'b0;
        pre_b    = 1'b0;
        pre_val  = '0;
        repeat (3) @(posedge clk);
        #1;
        p_reset = 1'b0;

        // Reset state of both instances.
        @(negedge clk);
        sel = 1'b0; #1;
        check_reset_outputs("reset_a");
        sel = 1'b1; #1;
        check_reset_outputs("reset_b");

        // wr_valid while idle must not be accepted.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            wr_valid = 1'b1;
            wr_data  = $urandom;
            @(negedge clk);
            check_eq("idle_wr_ready_a", bus_a.wr_ready, 0);
            check_eq("idle_wr_ready_b", bus_b.wr_ready, 0);
            check_eq("idle_busy_a", busy_a, 0);
        end
        wr_valid = 1'b0;

        // 64-bit chain, directed words and preload.
        wq = '{32'hA5A5A5A5, 32'h3C3C3C3C};
        run_load(1'b0, 64'hDEADBEEF_01234567, 0, 0, 0, 1'b0);
        check_eq("t1_chain_literal", chain_a, 64'hA5A5A5A5_3C3C3C3C);

        // 40-bit chain: truncated, left-aligned last word.
        wq = '{32'hFFFFFFFF, 32'hAB000000};
        run_load(1'b1, {$urandom, $urandom}, 0, 0, 0, 1'b0);
        check_eq("t2_last_bits", chain_b[7:0], 8'hAB);
        if (obs_q.size() > 1) begin
            w1 = obs_q[1];
            check_eq("t2_partial_low_zero", w1[23:0], 0);
        end

        // Starved input stream.
        fill_random_words(2);
        run_load(1'b0, {$urandom, $urandom}, 1, 0, 0, 1'b0);

        // Readback consumer stalled after first word.
        fill_random_words(2);
        run_load(1'b0, {$urandom, $urandom}, 0, 1, 0, 1'b0);

        // Abort at shift 17, then a clean load.
        fill_random_words(2);
        run_load(1'b0, {$urandom, $urandom}, 0, 0, 17, 1'b0);
        fill_random_words(2);
        run_load(1'b0, {$urandom, $urandom}, 0, 0, 0, 1'b0);

        // start pulsed mid-load is ignored.
        fill_random_words(2);
        run_load(1'b0, {$urandom, $urandom}, 0, 0, 0, 1'b1);

        // Randomized loads on both chain lengths with random handshakes.
        for (int r = 0; r < 6; r++) begin
            fill_random_words(2);
            run_load(($urandom_range(0, 1) == 1), {$urandom, $urandom}, 2, 2, 0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
